// File: rtl/expr_recognizer.sv
// Streaming recognizer for ASCII arithmetic expressions: multi-digit operands,
// + - * / operators and bounded parenthesis nesting, one byte per qualified edge.
module expr_recognizer #(
  parameter int DIGIT_MAX = 4,
  parameter int MAX_DEPTH = 3,
  parameter int CNT_W     = 8,
  localparam int DW       = ($clog2(MAX_DEPTH + 1) > 1) ? $clog2(MAX_DEPTH + 1) : 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       in,
  input  logic             in_valid,
  output logic             out,
  output logic             err,
  output logic [DW-1:0]    depth,
  output logic [CNT_W-1:0] num_cnt
);

  typedef enum logic [3:0] {
    S_START = 4'b0001,
    S_NUM   = 4'b0010,
    S_CLOSE = 4'b0100,
    S_ERR   = 4'b1000
  } state_t;

  state_t           state_reg, state_next;
  logic [3:0]       dcnt_reg, dcnt_next;
  logic [DW-1:0]    depth_reg, depth_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic is_digit, is_op, is_lpar, is_rpar;
  logic can_open, can_close, digit_room;

  assign is_digit = (in >= 8'd48) && (in <= 8'd57);
  assign is_op    = (in == 8'd43) || (in == 8'd45) || (in == 8'd42) || (in == 8'd47);
  assign is_lpar  = (in == 8'd40);
  assign is_rpar  = (in == 8'd41);

  // With MAX_DEPTH=0 can_open is constant 0, so '(' always errors.
  assign can_open   = (MAX_DEPTH > 0) && (int'(depth_reg) < MAX_DEPTH);
  assign can_close  = (depth_reg != '0);
  assign digit_room = (int'(dcnt_reg) < DIGIT_MAX);

  always_comb begin
    state_next = state_reg;
    dcnt_next  = dcnt_reg;
    depth_next = depth_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_START: begin
        if (in_valid) begin
          if (is_digit) begin
            state_next = S_NUM;
            dcnt_next  = 4'd1;
            if (cnt_reg != {CNT_W{1'b1}}) cnt_next = cnt_reg + CNT_W'(1);
          end else if (is_lpar && can_open) begin
            depth_next = depth_reg + DW'(1);
          end else begin
            state_next = S_ERR;
          end
        end
      end
      S_NUM: begin
        if (in_valid) begin
          if (is_digit && digit_room) begin
            dcnt_next = dcnt_reg + 4'd1;
          end else if (is_op) begin
            state_next = S_START;
            dcnt_next  = 4'd0;
          end else if (is_rpar && can_close) begin
            state_next = S_CLOSE;
            dcnt_next  = 4'd0;
            depth_next = depth_reg - DW'(1);
          end else begin
            state_next = S_ERR;
          end
        end
      end
      S_CLOSE: begin
        if (in_valid) begin
          if (is_op) begin
            state_next = S_START;
          end else if (is_rpar && can_close) begin
            depth_next = depth_reg - DW'(1);
          end else begin
            state_next = S_ERR;
          end
        end
      end
      S_ERR: state_next = S_ERR;
      // Corrupted encodings recover even when no byte is presented.
      default: state_next = S_START;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= S_START;
      dcnt_reg  <= 4'd0;
      depth_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      dcnt_reg  <= dcnt_next;
      depth_reg <= depth_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign out     = ((state_reg == S_NUM) || (state_reg == S_CLOSE)) && (depth_reg == '0);
  assign err     = (state_reg == S_ERR);
  assign depth   = depth_reg;
  assign num_cnt = cnt_reg;

endmodule

// File: doc/expr_recognizer.md
# expr_recognizer

Parametrised, streaming recognizer for arithmetic expression strings fed one ASCII byte per cycle. It generalises the single-digit `digit (op digit)*` checker to multi-digit operands, four operators and bounded parenthesis nesting. It also adds a byte-valid qualifier, a sticky error flag, and depth and operand-count status outputs. It sits on the character-stream path after the byte source and drives the "expression so far is well-formed" indication.

## Interface
- DIGIT_MAX, 4: maximum decimal digits per operand, 1..15.
- MAX_DEPTH, 3: maximum parenthesis nesting depth; 0 disables parentheses, so '(' and ')' become illegal.
- CNT_W, 8: width of the operand counter.
- DW, derived: max(1, clog2(MAX_DEPTH+1)); width of `depth`.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- clr  input  1  reset, asynchronous, active-high.
- in  input  8  ASCII byte.
- in_valid  input  1  `in` is consumed on an edge only when this is 1.
- out  output  1  1 when the bytes consumed since reset form a complete, balanced, legal expression.
- err  output  1  sticky illegal-sequence flag.
- depth  output  DW  current open-parenthesis count.
- num_cnt  output  CNT_W  operands started since reset; saturates at all-ones.

## Operation
- Character classes:
  - digit: 48..57.
  - op: '+' 43, '-' 45, '*' 42, '/' 47.
  - lpar: '(' 40.
  - rpar: ')' 41.
  - other: any remaining byte.
- States:
  - S_START: expects an operand.
  - S_NUM: inside an operand.
  - S_CLOSE: just after ')'.
  - S_ERR: sticky error.
  - Encoding is one-hot.
- Internal digit counter `dcnt` is 4 bits wide.
- Reset values: state S_START, dcnt 0, depth 0, num_cnt 0, out 0, err 0.
- When in_valid=0, nothing changes. When in_valid=1, transitions are:
  - S_START, digit: go to S_NUM, dcnt=1, num_cnt+1 (saturating).
  - S_START, lpar: if MAX_DEPTH>0 and depth<MAX_DEPTH, then depth+1 and stay in S_START; otherwise go to S_ERR.
  - S_START, op, rpar or other: go to S_ERR.
  - S_NUM, digit: if dcnt<DIGIT_MAX, then dcnt+1 and stay; otherwise go to S_ERR.
  - S_NUM, op: go to S_START, dcnt=0.
  - S_NUM, rpar: if depth>0, then depth-1, dcnt=0, go to S_CLOSE; otherwise go to S_ERR.
  - S_NUM, lpar or other: go to S_ERR.
  - S_CLOSE, op: go to S_START.
  - S_CLOSE, rpar: if depth>0, then depth-1 and stay; otherwise go to S_ERR.
  - S_CLOSE, digit, lpar or other: go to S_ERR.
  - S_ERR: stays in S_ERR regardless of input, leaving only via clr. depth, num_cnt and dcnt freeze at their values on entry.
  - Illegal or unreachable state encoding: return to S_START on the next edge.
- Output decode (combinational from registered state):
  - out = (state==S_NUM or state==S_CLOSE) and depth==0.
  - err = (state==S_ERR).
  - out and err are never both 1.
- Leading zeros are legal ("007" is one 3-digit operand).
- The empty string is not a valid expression, so out=0 after reset.

## Timing
- Latency: a byte sampled at edge k is reflected in out, err, depth and num_cnt immediately after edge k (one-edge latency). No combinational path from `in` to any output.
- clr is asynchronous: all state and outputs go to reset values immediately on assertion. While clr=1, in_valid is ignored.
- The first byte is consumed on the first rising edge with clr=0 and in_valid=1.
- clr asserted mid-expression discards all progress; there is no partial retention.
- Boundary behaviour:
  - Digit count: exactly DIGIT_MAX digits is legal; DIGIT_MAX+1 errors on that byte.
  - Nesting: depth reaching exactly MAX_DEPTH is legal; one more '(' errors.
  - num_cnt holds at 2^CNT_W-1 once reached and does not wrap.

## Test plan
- Defaults, stream "1+2*3" with in_valid=1: out after each edge 1,0,1,0,1; err 0; num_cnt ends at 3.
- MAX_DEPTH=2, stream "((12)-3)": depth 1,2,2,2,1,1,1,0; out high only after the final ')'; err 0.
- DIGIT_MAX=3, stream "1234": out 1,1,1, then err=1 on the 4th byte. A following "+5" leaves err=1, out=0, num_cnt=1.
- MAX_DEPTH=2, stream "(((": err rises on the 3rd byte with depth frozen at 2. Separately, "1)" errors on ')' and "2(" errors on '('.
- Hold and reset:
  - Stream "9" then "+" with in_valid=0 for 3 cycles: out stays 1 with no change.
  - Assert clr asynchronously between edges mid "(4": all outputs reset before the next edge, then "5" gives out=1, num_cnt=1.
- CNT_W=2, stream "1+1+1+1+1": num_cnt saturates at 3, out=1.
